// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the CHIP-8 memory between the ROM/font loader, the CPU
// and the display scanner.
// - The loader has strict priority.
// - The CPU and the display alternate round-robin.
// - The CPU can lock the memory for bursts.
// - A wait counter bounds how long the display can be held off.
// Grants and memory drive are combinational. Read data returns one cycle
// later, tagged with the reader that was granted.
module mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dsp_req,
    input  logic [ADDR_W-1:0] dsp_addr,
    output logic              dsp_gnt,
    output logic              dsp_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_wr_go,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              starved
);

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);
    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_LD   = 2'd1;
    localparam logic [1:0] TAG_CPU  = 2'd2;
    localparam logic [1:0] TAG_DSP  = 2'd3;

    logic              r_rr_ptr;      // 0: CPU preferred next, 1: display
    logic              r_lock;
    logic [7:0]        r_dsp_wait;
    logic              r_starved;
    logic [1:0]        r_tag;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_rd_addr;

    logic              w_forced;
    logic              w_ld_gnt;
    logic              w_cpu_gnt;
    logic              w_dsp_gnt;
    logic              w_wr_go;
    logic              w_rd_go;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [1:0]        w_tag_next;

    // Arbitration: loader, then forced display, then lock owner, then round-robin.
    always_comb begin
        w_forced  = dsp_req && (r_dsp_wait == LP_MAX_WAIT);
        w_ld_gnt  = 1'b0;
        w_cpu_gnt = 1'b0;
        w_dsp_gnt = 1'b0;
        if (ld_req) begin
            w_ld_gnt = 1'b1;
        end else if (w_forced) begin
            w_dsp_gnt = 1'b1;
        end else if (r_lock) begin
            // While locked the display only gets in through a forced grant.
            w_cpu_gnt = cpu_req;
        end else if (cpu_req && (!dsp_req || !r_rr_ptr)) begin
            w_cpu_gnt = 1'b1;
        end else if (dsp_req) begin
            w_dsp_gnt = 1'b1;
        end
    end

    // Memory port drive. Addresses and write data hold when not refreshed.
    always_comb begin
        w_wr_go    = (w_ld_gnt && ld_we) || (w_cpu_gnt && cpu_we);
        w_rd_go    = (w_ld_gnt && !ld_we) || (w_cpu_gnt && !cpu_we) || w_dsp_gnt;
        w_wr_addr  = w_ld_gnt ? ld_addr  : cpu_addr;
        w_wr_data  = w_ld_gnt ? ld_wdata : cpu_wdata;
        w_rd_addr  = w_ld_gnt ? ld_addr  : (w_cpu_gnt ? cpu_addr : dsp_addr);
        w_tag_next = TAG_NONE;
        if (w_rd_go) begin
            if (w_ld_gnt)       w_tag_next = TAG_LD;
            else if (w_cpu_gnt) w_tag_next = TAG_CPU;
            else                w_tag_next = TAG_DSP;
        end
    end

    assign ld_gnt      = w_ld_gnt;
    assign cpu_gnt     = w_cpu_gnt;
    assign dsp_gnt     = w_dsp_gnt;
    assign mem_wr_go   = w_wr_go;
    assign mem_wr_addr = w_wr_go ? w_wr_addr : r_wr_addr;
    assign mem_wr_data = w_wr_go ? w_wr_data : r_wr_data;
    assign mem_rd_addr = w_rd_go ? w_rd_addr : r_rd_addr;
    assign ld_rvalid   = (r_tag == TAG_LD);
    assign cpu_rvalid  = (r_tag == TAG_CPU);
    assign dsp_rvalid  = (r_tag == TAG_DSP);
    // Read data is forced to zero outside a return cycle so it is 0 in reset.
    assign rdata       = (r_tag != TAG_NONE) ? mem_rd_data : '0;
    assign starved     = r_starved;

    // Round-robin pointer and burst lock.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rr_ptr <= 1'b0;
            r_lock   <= 1'b0;
        end else begin
            if (w_cpu_gnt)      r_rr_ptr <= 1'b1;
            else if (w_dsp_gnt) r_rr_ptr <= 1'b0;
            if (w_cpu_gnt && cpu_lock) r_lock <= 1'b1;
            else if (!cpu_lock)        r_lock <= 1'b0;
        end
    end

    // Display wait counter and sticky starvation flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_dsp_wait <= 8'd0;
            r_starved  <= 1'b0;
        end else begin
            if (w_dsp_gnt || !dsp_req)       r_dsp_wait <= 8'd0;
            else if (r_dsp_wait < LP_MAX_WAIT) r_dsp_wait <= r_dsp_wait + 8'd1;
            if (w_dsp_gnt && w_forced) r_starved <= 1'b1;
        end
    end

    // Held memory addresses/data and the read-return tag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_addr <= '0;
            r_tag     <= TAG_NONE;
        end else begin
            r_wr_addr <= mem_wr_addr;
            r_wr_data <= mem_wr_data;
            r_rd_addr <= mem_rd_addr;
            r_tag     <= w_tag_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a behavioural model predicts each cycle's
// grant/memory drive and each read return. A monitor compares them against
// the DUT on the falling edge.
module tb_mem_arbiter;

    localparam int MAXW = 16;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        ld_req = 0, ld_we = 0, cpu_req = 0, cpu_we = 0, cpu_lock = 0, dsp_req = 0;
    logic [11:0] ld_addr = 0, cpu_addr = 0, dsp_addr = 0;
    logic [7:0]  ld_wdata = 0, cpu_wdata = 0;
    logic        ld_gnt, ld_rvalid, cpu_gnt, cpu_rvalid, dsp_gnt, dsp_rvalid;
    logic [7:0]  rdata, mem_wr_data, mem_rd_data;
    logic        mem_wr_go, starved;
    logic [11:0] mem_wr_addr, mem_rd_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(12), .DATA_W(8), .MAX_WAIT(MAXW)) dut (
        .clk_in(clk), .rst_in(rst_in),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_gnt(dsp_gnt), .dsp_rvalid(dsp_rvalid),
        .rdata(rdata), .mem_wr_go(mem_wr_go), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .starved(starved)
    );

    // Memory block: synchronous write, one-cycle registered read, backdoor fill.
    logic [7:0]  mem [4096];
    logic        bd_we = 0;
    logic [11:0] bd_addr = 0;
    logic [7:0]  bd_data = 0;
    always @(posedge clk) begin
        if (bd_we)          mem[bd_addr] <= bd_data;
        else if (mem_wr_go) mem[mem_wr_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_rd_addr];
    end

    typedef struct packed {
        logic [2:0]  gnt;      // {ld, cpu, dsp}
        logic        wr_go;
        logic [11:0] wr_addr;
        logic [7:0]  wr_data;
        logic [11:0] rd_addr;
        logic        stv;
    } exp_t;
    typedef struct packed {
        logic [2:0]  rv;
        logic [7:0]  data;
        int          due;
    } rd_t;

    exp_t exp_q[$];
    rd_t  rd_q[$];
    int   n_chk = 0, n_fail = 0, cyc_n = 0;
    bit   done = 0;

    // Reference model state.
    logic [7:0]  ref_mem [4096];
    int          m_last_rr;    // 2: CPU served last, 3: display served last
    bit          m_locked, m_starved;
    int          m_waited, m_win;
    logic [11:0] m_wa, m_ra;
    logic [7:0]  m_wd;

    // Stimulus for the current cycle.
    logic        s_lr, s_lw, s_cr, s_cw, s_cl, s_dr;
    logic [11:0] s_la, s_ca, s_da;
    logic [7:0]  s_ld, s_cd;

    task automatic model_reset();
        m_last_rr = 3; m_locked = 0; m_starved = 0; m_waited = 0; m_win = 0;
        m_wa = 0; m_ra = 0; m_wd = 0;
    endtask

    // One clock cycle: drive the stimulus and predict the DUT's response.
    task automatic apply();
        exp_t e;
        rd_t  r;
        bit   forced, is_wr;
        @(posedge clk); #1;
        cyc_n++;
        ld_req = s_lr; ld_we = s_lw; ld_addr = s_la; ld_wdata = s_ld;
        cpu_req = s_cr; cpu_we = s_cw; cpu_lock = s_cl; cpu_addr = s_ca; cpu_wdata = s_cd;
        dsp_req = s_dr; dsp_addr = s_da;
        forced = s_dr && (m_waited >= MAXW);
        if (s_lr)                m_win = 1;
        else if (forced)         m_win = 3;
        else if (m_locked)       m_win = s_cr ? 2 : 0;
        else if (s_cr && s_dr)   m_win = (m_last_rr == 2) ? 3 : 2;
        else if (s_cr)           m_win = 2;
        else if (s_dr)           m_win = 3;
        else                     m_win = 0;
        is_wr = (m_win == 1 && s_lw) || (m_win == 2 && s_cw);
        e.stv = m_starved;
        if (is_wr) begin
            m_wa = (m_win == 1) ? s_la : s_ca;
            m_wd = (m_win == 1) ? s_ld : s_cd;
        end else if (m_win != 0) begin
            m_ra = (m_win == 1) ? s_la : ((m_win == 2) ? s_ca : s_da);
            r.rv = (m_win == 1) ? 3'b100 : ((m_win == 2) ? 3'b010 : 3'b001);
            r.data = ref_mem[m_ra];
            r.due = cyc_n + 1;
            rd_q.push_back(r);
        end
        e.gnt = (m_win == 1) ? 3'b100 : (m_win == 2) ? 3'b010 : (m_win == 3) ? 3'b001 : 3'b000;
        e.wr_go = is_wr; e.wr_addr = m_wa; e.wr_data = m_wd; e.rd_addr = m_ra;
        exp_q.push_back(e);
        if (is_wr) ref_mem[m_wa] = m_wd;
        if (m_win == 2 || m_win == 3) m_last_rr = m_win;
        if (m_win == 2 && s_cl) m_locked = 1;
        else if (!s_cl)         m_locked = 0;
        if (m_win == 3 && forced) m_starved = 1;
        if (m_win == 3 || !s_dr) m_waited = 0;
        else if (m_waited < MAXW) m_waited++;
    endtask

    task automatic idle_stim();
        s_lr = 0; s_lw = 0; s_la = 0; s_ld = 0;
        s_cr = 0; s_cw = 0; s_cl = 0; s_ca = 0; s_cd = 0;
        s_dr = 0; s_da = 0;
    endtask

    // Monitor: compare predicted and observed responses every falling edge.
    initial begin
        exp_t e;
        rd_t  r;
        logic [2:0] rv;
        forever begin
            @(negedge clk);
            if (done) begin
                n_chk++;
                if (rd_q.size() != 0 || exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL drain: pending reads %0d grants %0d, required 0 and 0", rd_q.size(), exp_q.size());
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
            rv = {ld_rvalid, cpu_rvalid, dsp_rvalid};
            if (!rst_in) begin
                n_chk++;
                if ({ld_gnt, cpu_gnt, dsp_gnt, rv, mem_wr_go, mem_wr_addr, mem_wr_data,
                     mem_rd_addr, rdata, starved} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_outputs: gnt=%b rv=%b wr_go=%b wa=%h wd=%h ra=%h rdata=%h starved=%b, required all 0",
                             {ld_gnt, cpu_gnt, dsp_gnt}, rv, mem_wr_go, mem_wr_addr, mem_wr_data,
                             mem_rd_addr, rdata, starved);
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_chk++;
                if ({ld_gnt, cpu_gnt, dsp_gnt} !== e.gnt) begin
                    n_fail++;
                    $display("FAIL grant cyc %0d: got %b required %b", cyc_n, {ld_gnt, cpu_gnt, dsp_gnt}, e.gnt);
                end
                n_chk++;
                if ({mem_wr_go, mem_wr_addr, mem_wr_data, mem_rd_addr, starved} !==
                    {e.wr_go, e.wr_addr, e.wr_data, e.rd_addr, e.stv}) begin
                    n_fail++;
                    $display("FAIL memport cyc %0d: got go=%b wa=%h wd=%h ra=%h stv=%b required go=%b wa=%h wd=%h ra=%h stv=%b",
                             cyc_n, mem_wr_go, mem_wr_addr, mem_wr_data, mem_rd_addr, starved,
                             e.wr_go, e.wr_addr, e.wr_data, e.rd_addr, e.stv);
                end
            end
            if (rd_q.size() > 0 && rd_q[0].due == cyc_n) begin
                r = rd_q.pop_front();
                n_chk++;
                if (rv !== r.rv || rdata !== r.data) begin
                    n_fail++;
                    $display("FAIL readback cyc %0d: got rvalid=%b rdata=%h required rvalid=%b rdata=%h",
                             cyc_n, rv, rdata, r.rv, r.data);
                end
            end else begin
                n_chk++;
                if (rv !== 3'b000) begin
                    n_fail++;
                    $display("FAIL spurious_rvalid cyc %0d: got %b required 000", cyc_n, rv);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pend_l, pend_c, pend_d;
        model_reset();
        idle_stim();
        // Fill memory during reset; 0x200 holds 0xA2.
        for (int i = 0; i < 4096; i++) begin
            @(posedge clk); #1;
            bd_we = 1; bd_addr = 12'(i);
            bd_data = (i == 12'h200) ? 8'hA2 : 8'($urandom);
            ref_mem[i] = bd_data;
        end
        @(posedge clk); #1;
        bd_we = 0;
        rst_in = 1;

        // CPU read of 0x200.
        idle_stim(); s_cr = 1; s_ca = 12'h200; apply();
        idle_stim(); apply();

        // CPU and display both reading continuously: alternation.
        for (int i = 0; i < 8; i++) begin
            s_cr = 1; s_cw = 0; s_ca = 12'(12'h400 + i);
            s_dr = 1; s_da = 12'(12'h800 + i);
            apply();
        end
        idle_stim(); apply();

        // Loader writes 0x00..0x4F while the CPU waits to read 0x04F.
        for (int i = 0; i < 80; i++) begin
            s_lr = 1; s_lw = 1; s_la = 12'(i); s_ld = 8'(i);
            s_cr = 1; s_ca = 12'h04F;
            apply();
        end
        idle_stim(); s_cr = 1; s_ca = 12'h04F; apply();
        idle_stim(); apply();

        // Locked CPU with the display waiting: forced grant, lock remains.
        for (int i = 0; i < 24; i++) begin
            s_cr = 1; s_cl = 1; s_ca = 12'(12'h500 + i);
            s_dr = 1; s_da = 12'h600;
            apply();
        end
        idle_stim(); apply();

        // CPU write to 0x300, then display read of 0x300.
        idle_stim(); s_cr = 1; s_cw = 1; s_ca = 12'h300; s_cd = 8'h5C; apply();
        idle_stim(); s_dr = 1; s_da = 12'h300; apply();
        idle_stim(); apply();

        // Randomised traffic; a request is held until the model grants it.
        pend_l = 0; pend_c = 0; pend_d = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!pend_l) begin
                s_lr = ($urandom_range(0, 9) == 0); s_lw = 1'($urandom);
                s_la = 12'($urandom); s_ld = 8'($urandom);
            end
            if (!pend_c) begin
                s_cr = ($urandom_range(0, 9) < 6); s_cw = 1'($urandom);
                s_cl = ($urandom_range(0, 9) < 4);
                s_ca = 12'($urandom); s_cd = 8'($urandom);
            end
            if (!pend_d) begin
                s_dr = ($urandom_range(0, 9) < 6); s_da = 12'($urandom);
            end
            apply();
            pend_l = s_lr && (m_win != 1);
            pend_c = s_cr && (m_win != 2);
            pend_d = s_dr && (m_win != 3);
        end
        idle_stim(); apply();

        // Reset on the cycle after a CPU read grant: the read is discarded.
        idle_stim(); s_cr = 1; s_ca = 12'h123; apply();
        @(posedge clk); #1;
        rst_in = 0;
        ld_req = 0; cpu_req = 0; dsp_req = 0; cpu_lock = 0;
        cyc_n++;
        rd_q.delete();
        model_reset();
        idle_stim();
        repeat (3) begin @(posedge clk); #1; cyc_n++; end
        rst_in = 1;
        for (int i = 0; i < 4; i++) apply();

        // Short traffic after reset, then drain.
        idle_stim(); s_cr = 1; s_ca = 12'h04F; s_dr = 1; s_da = 12'h300; apply();
        s_ca = 12'h200; apply();
        idle_stim(); apply(); apply();
        @(posedge clk); #1;
        done = 1;
    end

endmodule
